// File: rtl/kmbox_spi_responder.sv
// SPI mode-0 slave for the kmbox link. Receives a fixed-length command frame
// per CS-low window, returns a status/counter response on MISO, and hands good
// frames to a valid/ready consumer.
module kmbox_spi_responder #(
  parameter int          FRAME_BITS = 64,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [31:0]           status_word,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                  state;
  logic [2:0]              sck_q;
  logic [2:0]              cs_q;
  logic [1:0]              mosi_q;
  logic [1:0]              prime;
  logic                    armed;
  logic [FRAME_BITS-1:0]   rx_sr;
  logic [62:0]             tx_sr;
  logic [CW-1:0]           bit_cnt;
  logic [7:0]              good_cnt;
  logic [7:0]              err_cnt;
  logic [7:0]              last_cmd;
  logic [63:0]             resp;
  logic                    sck_rise;
  logic                    cs_fall;
  logic                    cs_rise;

  // Edge strobes come from the synchronized stage vs. the extra third stage.
  always_comb begin
    sck_rise = sck_q[1] & ~sck_q[2];
    cs_fall  = ~cs_q[1] & cs_q[2];
    cs_rise  = cs_q[1] & ~cs_q[2];
    busy     = ~cs_q[1];
    resp     = {SYNC_BYTE, last_cmd, good_cnt, err_cnt, status_word};
  end

  // Input synchronizers; 'armed' requires CS to be seen high after reset so a
  // frame interrupted by reset is never resumed mid-way.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      prime  <= '0;
      armed  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
      if (prime != 2'd3) prime <= prime + 2'd1;
      if (prime == 2'd3 && cs_q[1]) armed <= 1'b1;
    end
  end

  // Frame FSM: response load, bit shifting, and end-of-frame bookkeeping.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      spi_miso  <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_sr     <= '0;
      tx_sr     <= '1;
      bit_cnt   <= '0;
      good_cnt  <= '0;
      err_cnt   <= '0;
      last_cmd  <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Consumption by default; a frame loading in DONE overrides this below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          spi_miso <= 1'b1;
          if (cs_fall && armed) state <= LOAD;
        end
        LOAD: begin
          spi_miso <= resp[63];
          tx_sr    <= resp[62:0];
          rx_sr    <= '0;
          bit_cnt  <= '0;
          // CS already back high: a glitch, closed out as a zero-bit frame.
          state    <= cs_rise ? DONE : SHIFT;
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= DONE;
          end else if (sck_rise) begin
            rx_sr    <= {rx_sr[FRAME_BITS-2:0], mosi_q[1]};
            spi_miso <= tx_sr[62];
            tx_sr    <= {tx_sr[61:0], 1'b1};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DONE: begin
          spi_miso <= 1'b1;
          state    <= IDLE;
          if (bit_cnt == CNT_FULL) begin
            good_cnt <= good_cnt + 8'd1;
            last_cmd <= rx_sr[FRAME_BITS-1 -: 8];
            if (!rx_valid || rx_ready) begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/kmbox_spi_responder.md
KMBOX_SPI_RESPONDER -- requirements
Module: kmbox_spi_responder

Interface
REQ-001 SHALL take parameter FRAME_BITS, default 64, meaning the bits per CS-low transaction.
REQ-002 SHALL take parameter SYNC_BYTE, default 8'hA5, meaning the constant in response byte 7.
REQ-003 SHALL have CLK, input, 1 bit: 48 MHz system clock; all logic rises on CLK.
REQ-004 SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have spi_sck, input, 1 bit: SPI clock from the FPGA master, mode 0, up to 12 MHz, asynchronous to CLK.
REQ-006 SHALL have spi_cs_n, input, 1 bit: active-low frame select.
REQ-007 SHALL have spi_mosi, input, 1 bit: master data, MSB first.
REQ-008 SHALL have spi_miso, output, 1 bit: response data, MSB first.
REQ-009 SHALL have rx_data, output, FRAME_BITS bits: last accepted frame.
REQ-010 SHALL have rx_valid, output, 1 bit: rx_data holds an unconsumed frame.
REQ-011 SHALL have rx_ready, input, 1 bit: consumer accepts rx_data.
REQ-012 SHALL have status_word, input, 32 bits: user status for response bytes 3..0.
REQ-013 SHALL have frame_err, output, 1 bit: one-CLK pulse on a short or long frame.
REQ-014 SHALL have overrun, output, 1 bit: one-CLK pulse when a good frame is dropped.
REQ-015 SHALL have busy, output, 1 bit: high while synchronized CS is low.

Function
REQ-016 SHALL pass spi_sck, spi_cs_n and spi_mosi through 2-FF synchronizers and derive rise/fall strobes from a third stage; all events SHALL use synchronized signals only.
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, DONE: IDLE->LOAD on CS fall; LOAD->SHIFT next CLK; SHIFT->DONE on CS rise; DONE->IDLE next CLK.
REQ-018 In LOAD, SHALL capture the response {SYNC_BYTE, last_cmd[7:0], good_cnt[7:0], err_cnt[7:0], status_word[31:0]} into the TX shift register and drive its MSB on spi_miso within 4 CLK of the actual CS fall.
REQ-019 In SHIFT, SHALL shift spi_mosi into the RX shift register on each SCK rise and increment bit_cnt, which saturates at FRAME_BITS+1.
REQ-020 On each SCK rise after sampling, SHALL present the next TX bit on spi_miso so it is stable before the following rise (at most 3 CLK after the rise at 12 MHz); SCK falls SHALL be ignored.
REQ-021 While CS is high, spi_miso SHALL be 1.
REQ-022 In DONE with bit_cnt==FRAME_BITS, the frame is good: SHALL increment good_cnt (8-bit, wraps 255->0) and set last_cmd to RX bits [63:56].
REQ-023 A good frame with rx_valid==0, or with rx_valid==1 and rx_ready==1 in the same CLK, SHALL load rx_data and assert rx_valid on the next CLK.
REQ-024 A good frame with rx_valid==1 and rx_ready==0 SHALL keep the old rx_data (first-wins) and pulse overrun.
REQ-025 In DONE with bit_cnt!=FRAME_BITS, SHALL pulse frame_err, increment err_cnt (8-bit, saturates at 255), and leave rx_data, rx_valid, good_cnt and last_cmd unchanged.
REQ-026 rx_valid SHALL clear on the CLK after rx_valid&&rx_ready unless a new frame loads in the same CLK.
REQ-027 rx_data SHALL stay stable while rx_valid is high.
REQ-028 A CS rise and a CS fall that are both detected before LOAD completes (a glitch) SHALL be treated as a zero-bit frame: frame_err pulses.
REQ-029 Latency from the synchronized CS rise to rx_valid high SHALL be 2 CLK.

Reset
REQ-030 rst_n low SHALL force state IDLE, spi_miso=1, rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0, bit_cnt=0, good_cnt=0, err_cnt=0, last_cmd=0, and synchronizers to idle (sck=0, cs_n=1).
REQ-031 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a fresh CS fall and ignore SCK edges while CS is low from the aborted frame.

Verification
REQ-032 SHALL verify: one 64-bit frame 0x0102030405060708 at 12 MHz -> rx_data=0x0102030405060708, rx_valid=1 two CLK after CS rise, good_cnt=1, last_cmd=0x01.
REQ-033 SHALL verify: second frame with status_word=0xDEADBEEF -> MISO returns 0xA5_01_01_00_DEADBEEF.
REQ-034 SHALL verify: 40-bit frame -> frame_err pulses once, err_cnt=1, rx_valid unchanged; the next response byte 4 is 0x01.
REQ-035 SHALL verify: two good frames with rx_ready held 0 -> first frame retained, overrun pulses once; with rx_ready=1 on the collision CLK, the second frame loads and overrun does not pulse.
REQ-036 SHALL verify: 256 good frames -> good_cnt wraps to 0x00; 300 short frames -> err_cnt saturates at 0xFF.
REQ-037 SHALL verify: rst_n pulsed after 20 bits -> all outputs at reset values, and the next full frame is received correctly.
